// File: rtl/vdc_video_timing.sv
// Raster timing generator for the VDC: splits the pixel-enable stream into dots, columns,
// scan lines and character rows, and derives syncs, display enable and fetch qualifiers.
module vdc_video_timing #(
    parameter int COL_BITS = 8,
    parameter int ROW_BITS = 8,
    parameter int MIN_CTH  = 3
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                enable,
    input  logic [COL_BITS-1:0] reg_ht,
    input  logic [COL_BITS-1:0] reg_hd,
    input  logic [COL_BITS-1:0] reg_hp,
    input  logic [7:0]          reg_sw,
    input  logic [ROW_BITS-1:0] reg_vt,
    input  logic [4:0]          reg_va,
    input  logic [ROW_BITS-1:0] reg_vd,
    input  logic [ROW_BITS-1:0] reg_vp,
    input  logic [4:0]          reg_ctv,
    input  logic [3:0]          reg_cth,
    output logic                newCol,
    output logic                endCol,
    output logic [COL_BITS-1:0] col,
    output logic [4:0]          line,
    output logic [ROW_BITS-1:0] row,
    output logic                adjust,
    output logic                fetchFrame,
    output logic                fetchRow,
    output logic                fetchLine,
    output logic                hsync,
    output logic                vsync,
    output logic                dispEn
);

    typedef struct packed {
        logic [4:0]          line;
        logic [ROW_BITS-1:0] row;
        logic                adj;
    } pos_t;

    logic [3:0] dot;
    logic [3:0] ecth;
    logic [4:0] hs_cnt;
    logic [4:0] vs_cnt;
    logic [4:0] hw;
    logic [4:0] vw;
    logic       col_wrap;
    logic       vs_trig;
    pos_t       cur;
    pos_t       nxt;
    pos_t       nxt2;

    // Vertical position one line later; shrinking registers recover via >= compares.
    function automatic pos_t advance(input pos_t p);
        pos_t n;
        n = p;
        if (p.adj) begin
            if (({1'b0, p.line} + 6'd1) >= {1'b0, reg_va}) begin
                n.line = '0;
                n.row  = '0;
                n.adj  = 1'b0;
            end else begin
                n.line = p.line + 5'd1;
            end
        end else if (p.line >= reg_ctv) begin
            n.line = '0;
            if (p.row >= reg_vt) begin
                if (reg_va == 5'd0) begin
                    n.row = '0;
                end else begin
                    n.adj = 1'b1;
                end
            end else begin
                n.row = p.row + ROW_BITS'(1);
            end
        end else begin
            n.line = p.line + 5'd1;
        end
        return n;
    endfunction

    function automatic logic displayed(input pos_t p);
        return !p.adj && (p.row < reg_vd);
    endfunction

    always_comb begin
        ecth     = (reg_cth < 4'(MIN_CTH)) ? 4'(MIN_CTH) : reg_cth;
        newCol   = reset_n && enable && (dot == 4'd0);
        endCol   = reset_n && enable && (dot >= ecth);
        col_wrap = endCol && (col >= reg_ht);
        cur      = '{line: line, row: row, adj: adjust};
        nxt      = advance(cur);
        nxt2     = advance(nxt);
        vs_trig  = (nxt.row == reg_vp) && (nxt.line == 5'd0) && !nxt.adj;
        hw       = (reg_sw[3:0] == 4'd0) ? 5'd16 : {1'b0, reg_sw[3:0]};
        vw       = (reg_sw[7:4] == 4'd0) ? 5'd16 : {1'b0, reg_sw[7:4]};
    end

    // Dot and column counters, vertical position and per-line qualifiers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dot        <= '0;
            col        <= '0;
            line       <= '0;
            row        <= '0;
            adjust     <= 1'b0;
            fetchFrame <= 1'b0;
            fetchRow   <= 1'b0;
            fetchLine  <= 1'b0;
            vsync      <= 1'b0;
            vs_cnt     <= '0;
        end else if (enable) begin
            dot <= endCol ? 4'd0 : dot + 4'd1;
            if (col_wrap) begin
                col        <= '0;
                line       <= nxt.line;
                row        <= nxt.row;
                adjust     <= nxt.adj;
                fetchFrame <= (nxt2.line == 5'd0) && (nxt2.row == '0) && !nxt2.adj;
                fetchRow   <= (nxt2.line == 5'd0) && (nxt2.row != '0) &&
                              (nxt2.row < reg_vd) && !nxt2.adj;
                fetchLine  <= displayed(nxt2);
                if (vs_trig) begin
                    vsync  <= 1'b1;
                    vs_cnt <= vw;
                end else if (vsync) begin
                    if (vs_cnt <= 5'd1) begin
                        vsync <= 1'b0;
                    end else begin
                        vs_cnt <= vs_cnt - 5'd1;
                    end
                end
            end else if (endCol) begin
                col <= col + COL_BITS'(1);
            end
        end
    end

    // Horizontal sync counts whole columns, so it runs across the line wrap
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hsync  <= 1'b0;
            hs_cnt <= '0;
            dispEn <= 1'b0;
        end else if (enable) begin
            if (newCol && (col == reg_hp)) begin
                hsync  <= 1'b1;
                hs_cnt <= hw;
            end else if (endCol && hsync) begin
                if (hs_cnt <= 5'd1) begin
                    hsync <= 1'b0;
                end else begin
                    hs_cnt <= hs_cnt - 5'd1;
                end
            end
            if (newCol) begin
                dispEn <= (col < reg_hd) && displayed(cur);
            end
        end
    end

endmodule
